// File: rtl/valet_cam_lot.sv
// CAM parking lot: stores (tag, ticket) pairs and serves park, retrieve,
// query and flush requests with a one-cycle registered response.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready, req_op, req_tag, req_data : request channel
//   rsp_valid/rsp_ready, rsp_status, rsp_index, rsp_data : response channel
//   count, full, empty : registered occupancy
module valet_cam_lot #(
    parameter int TAG_WIDTH  = 16,
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [TAG_WIDTH-1:0]       req_tag,
    input  logic [DATA_WIDTH-1:0]      req_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [1:0]                 rsp_status,
    output logic [$clog2(DEPTH)-1:0]   rsp_index,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        OP_QUERY    = 2'b00,
        OP_PARK     = 2'b01,
        OP_RETRIEVE = 2'b10,
        OP_FLUSH    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_MISS = 2'b01,
        ST_FULL = 2'b10,
        ST_DUP  = 2'b11
    } status_e;

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_d  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];

    logic                  rsp_valid_q, rsp_valid_d;
    logic [1:0]            rsp_status_q, rsp_status_d;
    logic [IW-1:0]         rsp_index_q, rsp_index_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;

    logic                  hit;
    logic [IW-1:0]         hit_idx;
    logic [IW-1:0]         free_idx;
    logic                  accept;

    // Descending scan so the lowest matching / free index is the one kept.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == req_tag) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!valid_q[i]) begin
                free_idx = IW'(i);
            end
        end
    end

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_status_d = rsp_status_q;
        rsp_index_d  = rsp_index_q;
        rsp_data_d   = rsp_data_q;
        count_d      = count_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_OK;
            rsp_index_d  = '0;
            rsp_data_d   = '0;
            unique case (op_e'(req_op))
                OP_PARK: begin
                    if (hit) begin
                        rsp_status_d = ST_DUP;
                        rsp_index_d  = hit_idx;
                    end else if (full_q) begin
                        rsp_status_d = ST_FULL;
                    end else begin
                        valid_d[free_idx] = 1'b1;
                        tag_d[free_idx]   = req_tag;
                        data_d[free_idx]  = req_data;
                        rsp_index_d       = free_idx;
                        count_d           = count_q + CW'(1);
                    end
                end
                OP_RETRIEVE, OP_QUERY: begin
                    if (hit) begin
                        rsp_index_d = hit_idx;
                        rsp_data_d  = data_q[hit_idx];
                        if (op_e'(req_op) == OP_RETRIEVE) begin
                            valid_d[hit_idx] = 1'b0;
                            if (count_q != '0) begin
                                count_d = count_q - CW'(1);
                            end
                        end
                    end else begin
                        rsp_status_d = ST_MISS;
                    end
                end
                OP_FLUSH: begin
                    valid_d = '0;
                    count_d = '0;
                end
                default: ;
            endcase
        end

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= '0;
            rsp_index_q  <= '0;
            rsp_data_q   <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
        end else begin
            valid_q      <= valid_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_index_q  <= rsp_index_d;
            rsp_data_q   <= rsp_data_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
        end
    end

    // Tag/data contents need no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = rsp_status_q;
    assign rsp_index  = rsp_index_q;
    assign rsp_data   = rsp_data_q;
    assign count      = count_q;
    assign full       = full_q;
    assign empty      = empty_q;

endmodule

// File: tb/tb_valet_cam_lot.sv
// Self-checking bench for valet_cam_lot: directed scenarios plus a
// randomized run against an array-based reference lot.
module tb_valet_cam_lot;

    localparam logic [1:0] QRY = 2'b00;
    localparam logic [1:0] PRK = 2'b01;
    localparam logic [1:0] RET = 2'b10;
    localparam logic [1:0] FLS = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [15:0] req_tag = '0;
    logic [7:0]  req_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_status;
    logic [2:0]  rsp_index;
    logic [7:0]  rsp_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference lot
    bit          m_valid [8];
    logic [15:0] m_tag   [8];
    logic [7:0]  m_data  [8];
    logic [1:0]  e_status;
    logic [2:0]  e_idx;
    logic [7:0]  e_data;

    valet_cam_lot #(.TAG_WIDTH(16), .DEPTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_tag(req_tag), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_index(rsp_index),
        .rsp_data(rsp_data),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += m_valid[i] ? 1 : 0;
        return c;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_op(input logic [1:0] op, input logic [15:0] tag,
                            input logic [7:0] data);
        int h = -1;
        int f = -1;
        for (int i = 0; i < 8; i++) begin
            if (h < 0 && m_valid[i] && m_tag[i] == tag) h = i;
            if (f < 0 && !m_valid[i]) f = i;
        end
        e_status = 2'd0;
        e_idx    = 3'd0;
        e_data   = 8'd0;
        case (op)
            PRK: begin
                if (h >= 0) begin
                    e_status = 2'd3;
                    e_idx    = 3'(h);
                end else if (f < 0) begin
                    e_status = 2'd2;
                end else begin
                    m_valid[f] = 1'b1;
                    m_tag[f]   = tag;
                    m_data[f]  = data;
                    e_idx      = 3'(f);
                end
            end
            RET, QRY: begin
                if (h >= 0) begin
                    e_idx  = 3'(h);
                    e_data = m_data[h];
                    if (op == RET) m_valid[h] = 1'b0;
                end else begin
                    e_status = 2'd1;
                end
            end
            default: m_clear();
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 with the response visible.
    task automatic do_op(input logic [1:0] op, input logic [15:0] tag,
                         input logic [7:0] data);
        req_valid = 1'b1;
        req_op    = op;
        req_tag   = tag;
        req_data  = data;
        model_op(op, tag, data);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1 ||
            full !== 1'b0 || rsp_status !== 2'd0 || rsp_index !== 3'd0 ||
            rsp_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b c=%0d e=%b f=%b st=%0d ix=%0d d=%0h exp v=0 c=0 e=1 f=0 0 0 0",
                     rsp_valid, count, empty, full, rsp_status, rsp_index, rsp_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b exp 1", req_ready);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            do_op(PRK, 16'h1000 + 16'(i), 8'h10 + 8'(i));
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_status !== 2'd0 ||
                rsp_index !== 3'(i) || rsp_data !== 8'd0) begin
                n_fail++;
                $display("FAIL fill_park%0d got v=%b st=%0d ix=%0d d=%0h exp 1 0 %0d 0",
                         i, rsp_valid, rsp_status, rsp_index, rsp_data, i);
            end
        end
        n_checks++;
        if (count !== 4'd8 || full !== 1'b1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_occ got c=%0d f=%b e=%b exp 8 1 0", count, full, empty);
        end
    endtask

    task automatic test_full_dup();
        do_op(PRK, 16'h2000, 8'h55);
        n_checks++;
        if (rsp_status !== 2'd2 || rsp_index !== 3'd0 || count !== 4'd8) begin
            n_fail++;
            $display("FAIL full_park got st=%0d ix=%0d c=%0d exp 2 0 8",
                     rsp_status, rsp_index, count);
        end
        do_op(PRK, 16'h1003, 8'h99);
        n_checks++;
        if (rsp_status !== 2'd3 || rsp_index !== 3'd3 ||
            rsp_data !== 8'd0 || count !== 4'd8) begin
            n_fail++;
            $display("FAIL dup_park got st=%0d ix=%0d d=%0h c=%0d exp 3 3 0 8",
                     rsp_status, rsp_index, rsp_data, count);
        end
    endtask

    task automatic test_retrieve_reuse();
        do_op(RET, 16'h1005, 8'h00);
        n_checks++;
        if (rsp_status !== 2'd0 || rsp_index !== 3'd5 || rsp_data !== 8'h15 ||
            count !== 4'd7 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL retrieve got st=%0d ix=%0d d=%0h c=%0d f=%b exp 0 5 15 7 0",
                     rsp_status, rsp_index, rsp_data, count, full);
        end
        do_op(QRY, 16'h1005, 8'h00);
        n_checks++;
        if (rsp_status !== 2'd1 || rsp_index !== 3'd0 || rsp_data !== 8'd0) begin
            n_fail++;
            $display("FAIL query_gone got st=%0d ix=%0d d=%0h exp 1 0 0",
                     rsp_status, rsp_index, rsp_data);
        end
        do_op(PRK, 16'h3000, 8'h30);
        n_checks++;
        if (rsp_status !== 2'd0 || rsp_index !== 3'd5 || count !== 4'd8) begin
            n_fail++;
            $display("FAIL hole_reuse got st=%0d ix=%0d c=%0d exp 0 5 8",
                     rsp_status, rsp_index, count);
        end
    endtask

    task automatic test_query_twice();
        for (int k = 0; k < 2; k++) begin
            do_op(QRY, 16'h1002, 8'h00);
            n_checks++;
            if (rsp_status !== 2'd0 || rsp_index !== 3'd2 ||
                rsp_data !== 8'h12 || count !== 4'd8) begin
                n_fail++;
                $display("FAIL query%0d got st=%0d ix=%0d d=%0h c=%0d exp 0 2 12 8",
                         k, rsp_status, rsp_index, rsp_data, count);
            end
        end
    endtask

    task automatic test_stall();
        do_op(RET, 16'h1002, 8'h00);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = QRY;
        req_tag   = 16'h1000;
        req_data  = 8'h00;
        #1;
        n_checks++;
        if (req_ready !== 1'b0 || rsp_status !== 2'd0 ||
            rsp_index !== 3'd2 || rsp_data !== 8'h12 || count !== 4'd7) begin
            n_fail++;
            $display("FAIL stall_start got rdy=%b st=%0d ix=%0d d=%0h c=%0d exp 0 0 2 12 7",
                     req_ready, rsp_status, rsp_index, rsp_data, count);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
                rsp_status !== 2'd0 || rsp_index !== 3'd2 ||
                rsp_data !== 8'h12) begin
                n_fail++;
                $display("FAIL stall_hold%0d got v=%b rdy=%b st=%0d ix=%0d d=%0h exp 1 0 0 2 12",
                         k, rsp_valid, req_ready, rsp_status, rsp_index, rsp_data);
            end
        end
        rsp_ready = 1'b1;
        model_op(QRY, 16'h1000, 8'h00);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 2'd0 ||
            rsp_index !== 3'd0 || rsp_data !== 8'h10) begin
            n_fail++;
            $display("FAIL stall_release got v=%b st=%0d ix=%0d d=%0h exp 1 0 0 10",
                     rsp_valid, rsp_status, rsp_index, rsp_data);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_once got v=%b exp 0", rsp_valid);
        end
    endtask

    task automatic test_flush_reset();
        do_op(FLS, 16'h0000, 8'h00);
        n_checks++;
        if (rsp_status !== 2'd0 || rsp_index !== 3'd0 || rsp_data !== 8'd0 ||
            count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL flush got st=%0d ix=%0d d=%0h c=%0d e=%b f=%b exp 0 0 0 0 1 0",
                     rsp_status, rsp_index, rsp_data, count, empty, full);
        end
        do_op(PRK, 16'h1001, 8'hA1);
        do_op(PRK, 16'h1004, 8'hA4);
        do_op(QRY, 16'h1001, 8'h00);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 2'd0 ||
            rsp_index !== 3'd0 || rsp_data !== 8'hA1 || count !== 4'd2) begin
            n_fail++;
            $display("FAIL repark_query got v=%b st=%0d ix=%0d d=%0h c=%0d exp 1 0 0 a1 2",
                     rsp_valid, rsp_status, rsp_index, rsp_data, count);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1 ||
            rsp_data !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b c=%0d e=%b d=%0h exp 0 0 1 0",
                     rsp_valid, count, empty, rsp_data);
        end
        m_clear();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_op(QRY, 16'h1001, 8'h00);
        n_checks++;
        if (rsp_status !== 2'd1 || rsp_data !== 8'd0) begin
            n_fail++;
            $display("FAIL post_reset_q1 got st=%0d d=%0h exp 1 0", rsp_status, rsp_data);
        end
        do_op(QRY, 16'h1004, 8'h00);
        n_checks++;
        if (rsp_status !== 2'd1 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL post_reset_q2 got st=%0d c=%0d exp 1 0", rsp_status, count);
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [15:0] tag;
        logic [7:0]  data;
        int          r;
        int          c;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 39);
            if (r == 0)       op = FLS;
            else if (r < 20)  op = PRK;
            else if (r < 30)  op = RET;
            else              op = QRY;
            tag  = 16'h5000 + 16'($urandom_range(0, 11));
            data = 8'($urandom);
            do_op(op, tag, data);
            c = m_count();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_status !== e_status ||
                rsp_index !== e_idx || rsp_data !== e_data ||
                count !== 4'(c) || full !== (c == 8) || empty !== (c == 0)) begin
                n_fail++;
                $display("FAIL rand%0d op=%0d tag=%0h got v=%b st=%0d ix=%0d d=%0h c=%0d f=%b e=%b exp 1 %0d %0d %0h %0d %b %b",
                         n, op, tag, rsp_valid, rsp_status, rsp_index, rsp_data,
                         count, full, empty, e_status, e_idx, e_data, c,
                         c == 8, c == 0);
            end
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_dup();
        test_retrieve_reuse();
        test_query_twice();
        test_stall();
        test_flush_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
